// File: rtl/hub_slot_sched_if.sv
// rtl/hub_slot_sched_if.sv - hub slot scheduler bus: cog run flags in, slot/strobe/counter out
interface hub_slot_sched_if #(
    parameter int NUMCOGS = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = (NUMCOGS > 1) ? $clog2(NUMCOGS) : 1
) ();
    logic [NUMCOGS-1:0] cog_ena;
    logic               nres;
    logic               ena_bus;
    logic [NUMCOGS-1:0] bus_sel;
    logic [IDX_W-1:0]   slot_idx;
    logic               slot_wrap;
    logic [CNT_W-1:0]   cnt;

    modport master (
        input  cog_ena,
        output nres, ena_bus, bus_sel, slot_idx, slot_wrap, cnt
    );

    modport slave (
        output cog_ena,
        input  nres, ena_bus, bus_sel, slot_idx, slot_wrap, cnt
    );
endinterface

// File: rtl/hub_slot_sched.sv
// rtl/hub_slot_sched.sv - hub slot rotation, bus phase strobe and system counter
// Optional HUB_SKIP_IDLE_EN: each slot update jumps to the next running cog.
module hub_slot_sched #(
    parameter int NUMCOGS = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = (NUMCOGS > 1) ? $clog2(NUMCOGS) : 1
) (
    input  logic             clk_cog,
    input  logic             inp_res,
    input  logic             soft_res,
    hub_slot_sched_if.master hub
);
    logic               nres_q;
    logic               ena_bus_q;
    logic               slot_wrap_q;
    logic [NUMCOGS-1:0] bus_sel_q;
    logic [NUMCOGS-1:0] sel_next;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   slot_idx_w;
    int                 cur_idx;
    int                 nxt_idx;

    always_comb begin
        slot_idx_w = '0;
        for (int i = 0; i < NUMCOGS; i++) begin
            if (bus_sel_q[i]) slot_idx_w = IDX_W'(i);
        end
    end

`ifdef HUB_SKIP_IDLE_EN
    int   base_idx;
    int   probe_idx;
    logic found;
`else
    logic cog_ena_unused;
    assign cog_ena_unused = ^hub.cog_ena;
`endif

    always_comb begin
        cur_idx = int'(slot_idx_w);
        if (bus_sel_q == '0 || cur_idx == NUMCOGS - 1) nxt_idx = 0;
        else                                            nxt_idx = cur_idx + 1;
`ifdef HUB_SKIP_IDLE_EN
        // Search starts at the fixed-rotation successor; the last probe lands on
        // the current slot so a lone running cog keeps the bus.
        found     = 1'b0;
        base_idx  = nxt_idx;
        probe_idx = 0;
        for (int i = 0; i < NUMCOGS; i++) begin
            probe_idx = base_idx + i;
            if (probe_idx >= NUMCOGS) probe_idx = probe_idx - NUMCOGS;
            for (int k = 0; k < NUMCOGS; k++) begin
                if (!found && k == probe_idx && hub.cog_ena[k]) begin
                    found   = 1'b1;
                    nxt_idx = k;
                end
            end
        end
`endif
        sel_next = '0;
        for (int i = 0; i < NUMCOGS; i++) sel_next[i] = (i == nxt_idx);
    end

    always_ff @(posedge clk_cog) begin
        if (inp_res) begin
            nres_q      <= 1'b0;
            ena_bus_q   <= 1'b0;
            bus_sel_q   <= '0;
            slot_wrap_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            nres_q      <= ~soft_res;
            slot_wrap_q <= 1'b0;
            if (!nres_q) begin
                // Idle bus drops the current slot; restart always begins at slot 0.
                ena_bus_q <= 1'b0;
                bus_sel_q <= '0;
            end else begin
                ena_bus_q <= ~ena_bus_q;
                cnt_q     <= cnt_q + CNT_W'(1);
                if (ena_bus_q) begin
                    bus_sel_q   <= sel_next;
                    slot_wrap_q <= sel_next[0];
                end
            end
        end
    end

    assign hub.nres      = nres_q;
    assign hub.ena_bus   = ena_bus_q;
    assign hub.bus_sel   = bus_sel_q;
    assign hub.slot_idx  = slot_idx_w;
    assign hub.slot_wrap = slot_wrap_q;
    assign hub.cnt       = cnt_q;
endmodule

// File: tb/tb_hub_slot_sched.sv
// tb/tb_hub_slot_sched.sv - scoreboard bench for hub_slot_sched (NUMCOGS 8, 5 and 1)
module tb_hub_slot_sched;
    logic clk_cog = 1'b0;
    always #5 clk_cog = ~clk_cog;

    logic inp_res;
    logic soft_res_m;
    logic soft_aux;

    hub_slot_sched_if #(.NUMCOGS(8), .CNT_W(8)) m_if ();
    hub_slot_sched_if #(.NUMCOGS(5), .CNT_W(8)) f_if ();
    hub_slot_sched_if #(.NUMCOGS(1), .CNT_W(8)) o_if ();

    hub_slot_sched #(.NUMCOGS(8), .CNT_W(8)) dut_m (
        .clk_cog(clk_cog), .inp_res(inp_res), .soft_res(soft_res_m), .hub(m_if));
    hub_slot_sched #(.NUMCOGS(5), .CNT_W(8)) dut_f (
        .clk_cog(clk_cog), .inp_res(inp_res), .soft_res(soft_aux), .hub(f_if));
    hub_slot_sched #(.NUMCOGS(1), .CNT_W(8)) dut_o (
        .clk_cog(clk_cog), .inp_res(inp_res), .soft_res(soft_aux), .hub(o_if));

    typedef struct {
        int         at;
        int         dut;
        logic [7:0] bus;
        logic       wrap;
        logic       nres;
        logic       ena;
        logic [7:0] cnt;
        bit         chk_bus;
    } exp_t;

    exp_t sb[$];
    int   ecnt = 0;
    bit   done = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk_cog) ecnt <= ecnt + 1;

    function automatic int ncogs(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 5 : 1);
    endfunction

    // Expected slot for clock k after reset release (slot 0 appears at k=3, 2 clocks per slot).
    function automatic logic [7:0] exp_bus(input int k, input int n, input bit skip);
        logic [7:0] one;
        int s;
        one = 8'h01;
        if (k < 3) return 8'h00;
        s = (k - 3) / 2;
        if (!skip) return one << (s % n);
        if (k < 11) return ((s % 2) == 0) ? 8'h04 : 8'h20;
        return one << ((s + 2) % 8);
    endfunction

    function automatic int enc(input logic [7:0] b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) if (b[i]) r = i;
        return r;
    endfunction

    task automatic push_one(input int at, input int d, input logic [7:0] bus, input logic wrap,
                            input logic nres, input logic ena, input logic [7:0] cnt, input bit chk_bus);
        exp_t e;
        e.at = at; e.dut = d; e.bus = bus; e.wrap = wrap; e.nres = nres;
        e.ena = ena; e.cnt = cnt; e.chk_bus = chk_bus;
        sb.push_back(e);
    endtask

    task automatic push_run(input int t0, input int k0, input int k1, input int base,
                            input int last_dut, input bit skip);
        logic [7:0] b;
        for (int k = k0; k <= k1; k++) begin
            for (int d = 0; d <= last_dut; d++) begin
                b = exp_bus(k, ncogs(d), skip && (d == 0));
                push_one(t0 + k, d, b, (k >= 3) && (k % 2 == 1) && (b == 8'h01),
                         1'b1, (k >= 2) && (k % 2 == 0), 8'((base + k - 1) & 255), 1'b1);
            end
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_cog);
        #1;
    endtask

    task automatic read_dut(input int d, output logic [7:0] b, output logic w, output logic n,
                            output logic e, output logic [7:0] c, output int idx);
        case (d)
            0: begin
                b = m_if.bus_sel; w = m_if.slot_wrap; n = m_if.nres;
                e = m_if.ena_bus; c = m_if.cnt; idx = int'(m_if.slot_idx);
            end
            1: begin
                b = {3'b000, f_if.bus_sel}; w = f_if.slot_wrap; n = f_if.nres;
                e = f_if.ena_bus; c = f_if.cnt; idx = int'(f_if.slot_idx);
            end
            default: begin
                b = {7'b0000000, o_if.bus_sel}; w = o_if.slot_wrap; n = o_if.nres;
                e = o_if.ena_bus; c = o_if.cnt; idx = int'(o_if.slot_idx);
            end
        endcase
    endtask

    int t0, s0, t1, t2;

    initial begin
        inp_res    = 1'b1;
        soft_res_m = 1'b0;
        soft_aux   = 1'b0;
`ifdef HUB_SKIP_IDLE_EN
        m_if.cog_ena = 8'h00;
`else
        m_if.cog_ena = 8'h24;
`endif
        f_if.cog_ena = 5'h00;
        o_if.cog_ena = 1'b0;

        wait_edges(3);
        for (int d = 0; d < 3; d++) push_one(ecnt, d, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        inp_res = 1'b0;
        t0 = ecnt;
        push_run(t0, 1, 357, 0, 2, 1'b0);
        wait_edges(357);

        // cnt reads 100 here; pulse soft reset for three clocks
        soft_res_m = 1'b1;
        s0 = ecnt;
        push_one(s0 + 1, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd101, 1'b0);
        push_one(s0 + 2, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd101, 1'b1);
        push_one(s0 + 3, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd101, 1'b1);
        wait_edges(3);
        soft_res_m = 1'b0;
        t1 = ecnt;
        push_run(t1, 1, 11, 101, 0, 1'b0);
        wait_edges(11);

        // bus_sel is 0x10 now; hard reset mid-rotation
        inp_res = 1'b1;
        for (int a = 1; a <= 2; a++)
            for (int d = 0; d < 3; d++) push_one(ecnt + a, d, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        wait_edges(2);
        inp_res = 1'b0;
        t2 = ecnt;
`ifdef HUB_SKIP_IDLE_EN
        m_if.cog_ena = 8'h24;
        push_run(t2, 1, 24, 0, 2, 1'b1);
        wait_edges(9);
        m_if.cog_ena = 8'h00;
        wait_edges(15);
`else
        push_run(t2, 1, 24, 0, 2, 1'b0);
        wait_edges(24);
`endif
        wait_edges(2);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, pending=%0d", sb.size());
        $fatal(1, "timeout");
    end

    exp_t        e;
    logic [7:0]  a_b, a_c;
    logic        a_w, a_n, a_e;
    int          a_idx;
    logic [18:0] act_v, exp_v, mask_v;

    always @(negedge clk_cog) begin
        if (ecnt > 0) begin
            for (int d = 0; d < 3; d++) begin
                read_dut(d, a_b, a_w, a_n, a_e, a_c, a_idx);
                checks++;
                if ($countones(a_b) > 1 || a_idx != enc(a_b)) begin
                    failures++;
                    $display("FAIL onehot_idx dut%0d edge%0d: bus_sel=%h slot_idx=%0d, required one-hot with slot_idx=%0d",
                             d, ecnt, a_b, a_idx, enc(a_b));
                end
            end
        end
        while (sb.size() > 0 && sb[0].at <= ecnt) begin
            e = sb.pop_front();
            read_dut(e.dut, a_b, a_w, a_n, a_e, a_c, a_idx);
            act_v  = {a_b, a_w, a_n, a_e, a_c};
            exp_v  = {e.bus, e.wrap, e.nres, e.ena, e.cnt};
            mask_v = e.chk_bus ? 19'h7FFFF : {8'h00, 1'b0, 1'b1, 1'b0, 8'hFF};
            checks++;
            if (e.at != ecnt || (act_v & mask_v) != (exp_v & mask_v)) begin
                failures++;
                $display("FAIL sb dut%0d edge%0d(at %0d): bus_sel=%h wrap=%b nres=%b ena_bus=%b cnt=%0d, required bus_sel=%h wrap=%b nres=%b ena_bus=%b cnt=%0d (bus fields checked=%0d)",
                         e.dut, ecnt, e.at, a_b, a_w, a_n, a_e, a_c,
                         e.bus, e.wrap, e.nres, e.ena, e.cnt, e.chk_bus);
            end
        end
        if (done) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end
endmodule
